// File: rtl/led_mode_sched_pkg.sv
// +------------------------------------------------------------------+
// | led_mode_sched_pkg : mode encoding shared by the LED scheduler     |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package led_mode_sched_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_RUN   = 2'd2,
    MODE_FAST  = 2'd3
  } mode_e;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:   next_mode = MODE_BLINK;
      MODE_BLINK: next_mode = MODE_RUN;
      MODE_RUN:   next_mode = MODE_FAST;
      default:    next_mode = MODE_OFF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// +------------------------------------------------------------------+
// | key_debounce : synchronise, debounce and edge-detect a push key    |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module key_debounce #(
  parameter int DB_CNT = 1_000_000
) (
  input  logic clk50M,
  input  logic RSTn,
  input  logic key_n,
  output logic press
);

  localparam int            CW       = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic          db_dly_q, db_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    db_dly_d = db_q;
    db_d     = db_q;
    cnt_d    = '0;
    // Only a disagreement that persists DB_CNT cycles flips the debounced level
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk50M or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      db_q     <= 1'b1;
      db_dly_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = db_dly_q & ~db_q;

endmodule

`default_nettype wire

// File: rtl/led_mode_sched.sv
// +------------------------------------------------------------------+
// | led_mode_sched : button-selected LED blink modes with tick divider |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module led_mode_sched
  import led_mode_sched_pkg::*;
#(
  parameter int N_LED    = 4,
  parameter int TICK_DIV = 25_000_000,
  parameter int DB_CNT   = 1_000_000
) (
  input  logic              clk50M,
  input  logic              RSTn,
  input  logic              key_n,
  output logic [N_LED-1:0]  led,
  output logic [MODE_W-1:0] mode
);

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TERM_SLOW = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TERM_FAST = TW'(TICK_DIV / 4 - 1);

  logic             press;
  logic             tick;
  logic [TW-1:0]    tick_last;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  mode_e            mode_q, mode_d;
  logic [N_LED-1:0] led_q, led_d;

  function automatic logic [N_LED-1:0] entry_pattern(input mode_e m);
    case (m)
      MODE_BLINK, MODE_FAST: entry_pattern = '0;
      MODE_RUN:              entry_pattern = {{(N_LED-1){1'b1}}, 1'b0};
      default:               entry_pattern = '1;
    endcase
  endfunction

  key_debounce #(
    .DB_CNT(DB_CNT)
  ) u_key_debounce (
    .clk50M(clk50M),
    .RSTn  (RSTn),
    .key_n (key_n),
    .press (press)
  );

  assign tick_last = (mode_q == MODE_FAST) ? TERM_FAST : TERM_SLOW;
  assign tick      = (tcnt_q == tick_last);

  always_comb begin
    tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    mode_d = mode_q;
    led_d  = led_q;
    // A press restarts the tick period so the new mode gets a full first step
    if (press) begin
      tcnt_d = '0;
      mode_d = next_mode(mode_q);
      led_d  = entry_pattern(mode_d);
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK, MODE_FAST: led_d = ~led_q;
        MODE_RUN:              led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
        default:               led_d = '1;
      endcase
    end
  end

  always_ff @(posedge clk50M or negedge RSTn) begin
    if (!RSTn) begin
      tcnt_q <= '0;
      mode_q <= MODE_OFF;
      led_q  <= '1;
    end else begin
      tcnt_q <= tcnt_d;
      mode_q <= mode_d;
      led_q  <= led_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

`default_nettype wire

// File: doc/led_mode_sched.md
Name: led_mode_sched

Overview:
- Sequences the board LEDs through blink modes selected by a push button.
- Contains:
  - a debounced key-press detector;
  - a 4-state mode FSM;
  - a programmable tick divider, one tick per LED update;
  - the LED pattern registers.
- Sits at top level between the 50 MHz system clock, the reset key, a user key and the LED bank.
- Extends the free-running blink counter into a mode-controlled scheduler.

Parameters:
- N_LED, 4, number of LEDs driven (min 2).
- TICK_DIV, 25_000_000, clock cycles per slow tick: 0.5 s at 50 MHz. Must be a multiple of 4, min 8.
- DB_CNT, 1_000_000, cycles the synchronised key must be stable before it is accepted: 20 ms at 50 MHz. Min 2.

Ports:
- clk50M  input  1  system clock, 50 MHz.
- RSTn  input  1  asynchronous active-low reset.
- key_n  input  1  user button, active-low, asynchronous to clk50M, bouncy.
- led  output  N_LED  LED drive, active-low (0 = lit).
- mode  output  2  current mode code, registered.

Behaviour:
Clock and reset (already decided):
- One clock, clk50M. Reset RSTn is asynchronous, active-low.
- While RSTn=0: led = all 1s, mode = 0. All counters, synchronisers and the debounced state are cleared; debounced state clears to 1 (released).
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge.
- After reset release, the first tick occurs exactly TICK_DIV cycles later.

Key path:
- key_n passes through a 2-FF synchroniser.
- Stability counter:
  - Counts while the synchronised value differs from the debounced state.
  - Clears whenever they are equal.
  - On reaching DB_CNT-1, the debounced state takes the new value and the counter clears.
- press is a 1-cycle pulse on the debounced 1→0 transition.
- Only one press per push. The key must be debounced-released before another press can be generated.

Mode FSM (mode encoding):
- 0 OFF → 1 BLINK → 2 RUN → 3 FAST → 0 OFF. Advances on each press, wraps at 3.

Tick divider:
- Counter runs 0..T-1 and wraps.
  - T = TICK_DIV in BLINK, RUN and OFF.
  - T = TICK_DIV/4 in FAST.
- tick is a 1-cycle pulse when the counter equals T-1.
- The counter clears on press.

LED update, registered; updates on the edge where tick or press is sampled:
- On press, mode and led are both loaded with the new mode's entry pattern on the same edge:
  - OFF: all 1s.
  - BLINK: all 0s.
  - RUN: all 1s except bit0 = 0.
  - FAST: all 0s.
- On tick, with no press in the same cycle:
  - OFF: led held at all 1s.
  - BLINK, FAST: led = ~led.
  - RUN: rotate left by 1. The bit at MSB wraps to bit0, so exactly one LED is lit at all times.
- Press and tick in the same cycle: the press wins, the tick is discarded and the counter clears.
- Otherwise led and mode hold.

Latency:
- From a clean key_n fall to the mode change: 2 sync cycles + DB_CNT cycles + 1 cycle. With DB_CNT=4 this is ≤ DB_CNT+3 cycles.
- From press to the first tick in the new mode: exactly T cycles.

Widths:
- Tick counter: clog2(TICK_DIV) bits.
- Debounce counter: clog2(DB_CNT) bits.
- Comparisons are unsigned. No overflow is possible because both counters wrap at their terminal value.

Decomposition:
- Shared package:
  - Mode encoding constants MODE_OFF=0, MODE_BLINK=1, MODE_RUN=2, MODE_FAST=3.
  - Mode width constant MODE_W=2.
- One sub-module: key_debounce.
  - Parameter: DB_CNT.
  - Ports: clk50M, RSTn, key_n, press.
  - Contains the synchroniser, stability counter and edge detector.
- Tick divider, FSM and LED registers stay in led_mode_sched.

Test Plan:
All scenarios use N_LED=4, TICK_DIV=8, DB_CNT=4.

1. Reset, then idle 100 cycles with key_n=1 → led=4'b1111, mode=0 throughout. No tick-driven change occurs in OFF.
2. key_n held low 20 cycles, then high → mode=1 and led=4'b0000 within 7 cycles of the fall. Afterwards led alternates 1111/0000 every 8 cycles. The release generates no further mode change.
3. Bounce: key_n driven low for 2 cycles, high for 2 cycles, repeated 10 times, then held high → mode stays 0, led stays 1111.
4. Two clean presses → mode=2, led=1110. Then 1101, 1011, 0111, 1110 at 8-cycle intervals, showing the wrap from MSB to bit0.
5. Third press → mode=3, led=0000, toggling every 2 cycles. Fourth press → mode=0, led=1111. Additionally, force a press coincident with a tick → no extra toggle, and the next tick arrives exactly T cycles after the press.
6. Assert RSTn=0 mid-RUN, between clock edges → led=1111 and mode=0 immediately. After release, a single press gives mode=1, and the first BLINK toggle occurs 8 cycles after that press.
